// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of a synchronous FIFO among N_REQ producers.
//   Round-robin arbitration with bursts of at most MAX_BURST beats per owner.
//   Writes are issued from registers and only when the FIFO is sure to have
//   room. The FIFO's ack/overflow response is monitored and sticky error
//   flags are kept.
//
// Ports
//   clk             rising-edge system clock
//   rst_n           asynchronous active-low reset (shared with the FIFO)
//   req_valid       per-requester data valid
//   req_data        requester i data at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   req_ready       one-hot (or zero) grant, combinational
//   fifo_data_in    registered FIFO write data
//   fifo_wr_en      registered FIFO write enable, one pulse per beat
//   fifo_full       FIFO full
//   fifo_almostfull FIFO has exactly one free slot
//   fifo_wr_ack     FIFO ack, one cycle after an accepted write
//   fifo_overflow   FIFO overflow, one cycle after a rejected write
//   grant_id        index of the last granted requester
//   wr_count        accepted-beat counter, wraps
//   err_clr         synchronous clear of the sticky error flags
//   err_overflow    sticky: fifo_overflow was seen
//   err_noack       sticky: a write was not acknowledged on the next cycle
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  output logic                        fifo_wr_en,
  input  logic                        fifo_full,
  input  logic                        fifo_almostfull,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic [15:0]                 wr_count,
  input  logic                        err_clr,
  output logic                        err_overflow,
  output logic                        err_noack
);

  localparam int         IDX_W     = $clog2(N_REQ);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_q, state_d;
  // ptr_q is both the round-robin pointer and, in BURST, the burst owner:
  // it is loaded with the winner on every grant.
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic [FIFO_WIDTH-1:0]  data_q, data_d;
  logic                   wr_en_q, wr_en_d;
  logic [15:0]            wr_count_q, wr_count_d;
  logic                   chk_q, chk_d;
  logic                   err_ovf_q, err_ovf_d;
  logic                   err_noack_q, err_noack_d;

  logic                   space;
  logic                   own_ok;
  logic                   rr_found;
  logic [IDX_W-1:0]       rr_idx;
  logic [IDX_W-1:0]       scan_idx;
  logic                   grant_vld;
  logic                   grant_cont;
  logic [IDX_W-1:0]       grant_idx;

  // Arbitration (combinational)
  always_comb begin
    // A write already on the port will consume the last free slot.
    space = !fifo_full && !(wr_en_q && fifo_almostfull);

    rr_found = 1'b0;
    rr_idx   = '0;
    scan_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!rr_found && req_valid[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end

    // Owner still valid with beats left: it either continues or stalls,
    // but nobody else may take the port.
    own_ok = (state_q == BURST) && req_valid[ptr_q] && (cnt_q < BURST_MAX);

    grant_vld  = 1'b0;
    grant_cont = 1'b0;
    grant_idx  = rr_idx;
    if (rst_n && space) begin
      if (own_ok) begin
        grant_vld  = 1'b1;
        grant_cont = 1'b1;
        grant_idx  = ptr_q;
      end else if (rr_found) begin
        grant_vld = 1'b1;
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant_vld && (grant_idx == IDX_W'(i));
    end
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_id_d  = grant_id_q;
    data_d      = data_q;
    wr_count_d  = wr_count_q;
    wr_en_d     = grant_vld;
    chk_d       = wr_en_q;

    if (grant_vld) begin
      state_d    = BURST;
      ptr_d      = grant_idx;
      grant_id_d = grant_idx;
      cnt_d      = grant_cont ? cnt_q + 4'd1 : 4'd1;
      wr_count_d = wr_count_q + 16'd1;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_idx == IDX_W'(i)) data_d = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end else if (!own_ok) begin
      state_d = IDLE;
    end

    // A new error wins over a simultaneous clear.
    if (chk_q && !fifo_wr_ack) err_noack_d = 1'b1;
    else if (err_clr)          err_noack_d = 1'b0;
    else                       err_noack_d = err_noack_q;

    if (fifo_overflow) err_ovf_d = 1'b1;
    else if (err_clr)  err_ovf_d = 1'b0;
    else               err_ovf_d = err_ovf_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(N_REQ - 1);
      cnt_q       <= 4'd0;
      grant_id_q  <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_count_q  <= 16'd0;
      chk_q       <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_noack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_id_q  <= grant_id_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      wr_count_q  <= wr_count_d;
      chk_q       <= chk_d;
      err_ovf_q   <= err_ovf_d;
      err_noack_q <= err_noack_d;
    end
  end

  assign fifo_data_in = data_q;
  assign fifo_wr_en   = wr_en_q;
  assign grant_id     = grant_id_q;
  assign wr_count     = wr_count_q;
  assign err_overflow = err_ovf_q;
  assign err_noack    = err_noack_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int MB    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic           err_clr;

  logic [N-1:0]   req_ready;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_wr_en;
  logic [1:0]     grant_id;
  logic [15:0]    wr_count;
  logic           err_overflow, err_noack;

  logic           fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  int             fcount;
  bit             pop, noack_force, ovf_force;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .N_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .grant_id(grant_id), .wr_count(wr_count), .err_clr(err_clr),
    .err_overflow(err_overflow), .err_noack(err_noack));

  // Second instance in pure round-robin mode, on a FIFO that never fills.
  logic [N-1:0]   rr_ready;
  logic [W-1:0]   rr_data;
  logic           rr_wr_en, rr_ack, rr_eov, rr_eno;
  logic [1:0]     rr_gid;
  logic [15:0]    rr_cnt;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .N_REQ(N), .MAX_BURST(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr_ready), .fifo_data_in(rr_data), .fifo_wr_en(rr_wr_en),
    .fifo_full(1'b0), .fifo_almostfull(1'b0),
    .fifo_wr_ack(rr_ack), .fifo_overflow(1'b0),
    .grant_id(rr_gid), .wr_count(rr_cnt), .err_clr(1'b0),
    .err_overflow(rr_eov), .err_noack(rr_eno));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ack <= 1'b0;
    else        rr_ack <= rr_wr_en;
  end

  // Behavioural FIFO of depth DEPTH seen by the main instance.
  assign fifo_full       = (fcount == DEPTH);
  assign fifo_almostfull = (fcount == DEPTH - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcount        <= 0;
      fifo_wr_ack   <= 1'b0;
      fifo_overflow <= 1'b0;
    end else begin
      fifo_wr_ack   <= fifo_wr_en && (fcount < DEPTH) && !noack_force;
      fifo_overflow <= (fifo_wr_en && (fcount == DEPTH)) || ovf_force;
      fcount        <= fcount + ((fifo_wr_en && fcount < DEPTH) ? 1 : 0)
                              - ((pop && fcount > 0) ? 1 : 0);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Reference model: rules of arbitration expressed on "last granted" and
  // "beats in the current run", not on the design's registers.
  int          m_last, m_run, m_gid;
  bit          m_burst, m_wr, m_chk, m_eno, m_eov;
  logic [15:0] m_data, m_cnt;

  function automatic bit vbit(input int i);
    logic [N-1:0] t;
    t = req_valid >> i;
    return t[0];
  endfunction

  task automatic model_step();
    logic [N-1:0]   one;
    logic [N-1:0]   rdy;
    logic [N*W-1:0] sh;
    int             eg;
    bit             cont, space;
    if (!rst_n) begin
      m_last = N - 1; m_run = 0; m_gid = 0; m_burst = 0; m_wr = 0; m_chk = 0;
      m_eno = 0; m_eov = 0; m_data = '0; m_cnt = '0;
    end
    eg = -1; cont = 0; one = 1;
    space = !fifo_full && !(m_wr && fifo_almostfull);
    if (rst_n && space) begin
      if (m_burst && vbit(m_last) && m_run < MB) begin
        eg = m_last; cont = 1;
      end else begin
        for (int k = 1; k <= N; k++)
          if (eg < 0 && vbit((m_last + k) % N)) eg = (m_last + k) % N;
      end
    end
    rdy = (eg >= 0) ? (one << eg) : '0;
    chk("req_ready",    64'(req_ready),    64'(rdy));
    chk("fifo_wr_en",   64'(fifo_wr_en),   64'(m_wr));
    chk("fifo_data_in", 64'(fifo_data_in), 64'(m_data));
    chk("wr_count",     64'(wr_count),     64'(m_cnt));
    chk("grant_id",     64'(grant_id),     64'(m_gid));
    chk("err_noack",    64'(err_noack),    64'(m_eno));
    chk("err_overflow", 64'(err_overflow), 64'(m_eov));
    if (rst_n) begin
      m_eno = (m_chk && !fifo_wr_ack) ? 1'b1 : (err_clr ? 1'b0 : m_eno);
      m_eov = fifo_overflow ? 1'b1 : (err_clr ? 1'b0 : m_eov);
      m_chk = m_wr;
      if (eg >= 0) begin
        sh      = req_data >> (eg * W);
        m_data  = sh[W-1:0];
        m_wr    = 1;
        m_cnt   = m_cnt + 16'd1;
        m_gid   = eg;
        m_run   = cont ? m_run + 1 : 1;
        m_last  = eg;
        m_burst = 1;
      end else begin
        m_wr = 0;
        if (!(m_burst && vbit(m_last) && m_run < MB)) m_burst = 0;
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input bit clr);
    req_valid = v;
    err_clr   = clr;
    req_data  = {$urandom, $urandom};
  endtask

  task automatic mid();
    @(negedge clk);
    model_step();
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [N-1:0] v, input bit clr);
    drive(v, clr);
    mid();
    edge_();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, 1'b0);
    mid();
    edge_();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] rdy;
  } vec_t;

  vec_t t2[16];
  vec_t t3[12];
  int   grants;

  initial begin
    for (int i = 0; i < 16; i++) begin
      t2[i].valid = 4'hF;
      t2[i].rdy   = 4'b0001 << (i / 4);
    end
    t3 = '{'{4'b1101, 4'b0001}, '{4'b1101, 4'b0100}, '{4'b1101, 4'b1000},
           '{4'b1101, 4'b0001}, '{4'b1101, 4'b0100}, '{4'b0010, 4'b0010},
           '{4'b0000, 4'b0000}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
           '{4'b1111, 4'b0001}, '{4'b0011, 4'b0010}, '{4'b0011, 4'b0001}};

    rst_n = 1'b0; pop = 0; noack_force = 0; ovf_force = 0;
    drive('0, 1'b0);
    mid();
    edge_();
    rst_n = 1'b1;

    // Async reset in the middle of a burst
    pop = 1;
    repeat (6) run(4'hF, 1'b0);
    chk("pre_reset_wr_en", 64'(fifo_wr_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_en",    64'(fifo_wr_en),   64'd0);
    chk("rst_data",     64'(fifo_data_in), 64'd0);
    chk("rst_wr_count", 64'(wr_count),     64'd0);
    chk("rst_grant_id", 64'(grant_id),     64'd0);
    chk("rst_ready",    64'(req_ready),    64'd0);
    mid();
    edge_();
    rst_n = 1'b1;

    // All requesters valid, bursts of MB: req0 first
    for (int i = 0; i < 16; i++) begin
      drive(t2[i].valid, 1'b0);
      mid();
      chk("t2_ready", 64'(req_ready), 64'(t2[i].rdy));
      edge_();
    end
    chk("t2_wr_count", 64'(wr_count), 64'd16);

    // Pure round-robin instance
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(t3[i].valid, 1'b0);
      mid();
      chk("t3_rr_ready", 64'(rr_ready), 64'(t3[i].rdy));
      edge_();
    end

    // Owner drops valid mid-burst: next requester takes over at once
    do_reset();
    run(4'b1100, 1'b0);
    run(4'b1100, 1'b0);
    drive(4'b1000, 1'b0);
    mid();
    chk("t6_switch_ready", 64'(req_ready), 64'b1000);
    edge_();
    chk("t6_grant_id", 64'(grant_id), 64'd3);

    // Missing ack and overflow flags
    do_reset();
    noack_force = 1;
    run(4'b0001, 1'b0);
    run('0, 1'b0);
    run('0, 1'b0);
    chk("t5_noack_set", 64'(err_noack), 64'd1);
    run('0, 1'b0);
    run('0, 1'b0);
    chk("t5_noack_held", 64'(err_noack), 64'd1);
    run('0, 1'b1);
    chk("t5_noack_clr", 64'(err_noack), 64'd0);
    run(4'b0001, 1'b0);
    run('0, 1'b0);
    run('0, 1'b1);
    chk("t5_clr_vs_miss", 64'(err_noack), 64'd1);
    run('0, 1'b1);
    chk("t5_noack_clr2", 64'(err_noack), 64'd0);
    noack_force = 0;
    ovf_force = 1;
    run('0, 1'b0);
    ovf_force = 0;
    run('0, 1'b1);
    chk("t5_ovf_vs_clr", 64'(err_overflow), 64'd1);
    run('0, 1'b1);
    chk("t5_ovf_clr", 64'(err_overflow), 64'd0);

    // Stream into a FIFO that is never drained
    do_reset();
    pop = 0;
    grants = 0;
    for (int i = 0; i < 20; i++) begin
      drive(4'b0010, 1'b0);
      mid();
      if (req_ready != '0) grants++;
      edge_();
    end
    chk("t4_grants", 64'(grants), 64'd8);
    drive(4'b0010, 1'b0);
    mid();
    chk("t4_ready_full", 64'(req_ready), 64'd0);
    edge_();
    chk("t4_no_overflow", 64'(err_overflow), 64'd0);
    chk("t4_no_noack",    64'(err_noack),    64'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pop         = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
      noack_force = ($urandom_range(0, 39) == 0);
      ovf_force   = ($urandom_range(0, 59) == 0);
      run(N'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
